// File: rtl/freq_meter.sv
// freq_meter: gated frequency counter for an asynchronous input.
// Counts synchronized rising edges of sig_in over a gate of
// clock_frequency*1000*gate_ms clk cycles and publishes the count.
// Optional feature macro: FREQ_METER_BCD_EN adds the bcd output. A
// sequential double-dabble converter then delays the strobe by
// count_width+1 cycles.
module freq_meter #(
  parameter int clock_frequency = 50,
  parameter int gate_ms         = 1000,
  parameter int count_width     = 32,
  parameter int bcd_digits      = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   sig_in,
  output logic [count_width-1:0] freq,
  output logic                   freq_valid,
  output logic                   overflow,
  output logic                   busy
`ifdef FREQ_METER_BCD_EN
  ,
  output logic [4*bcd_digits-1:0] bcd
`endif
);

  localparam int GC = clock_frequency * 1000 * gate_ms;
  localparam int GW = (GC > 1) ? $clog2(GC) : 1;
  localparam logic [GW-1:0]          GC_LAST = GW'(GC - 1);
  localparam logic [count_width-1:0] CNT_MAX = {count_width{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GATE  = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_sync1;
  logic                   r_sync2;
  logic                   r_prev;
  logic                   w_edge;
  logic [GW-1:0]          r_gate_cnt;
  logic [count_width-1:0] r_edge_cnt;
  logic                   r_ovf;
  logic                   w_in_gate;
  logic                   w_abort;
  logic                   w_latch;
  logic [count_width-1:0] r_freq;
  logic                   r_freq_valid;
  logic                   r_overflow;
  logic                   r_busy;

  assign w_edge    = r_sync2 & ~r_prev;
  assign w_in_gate = (r_state == S_GATE) && en;
  assign w_abort   = (r_state == S_GATE) && !en;
  assign w_latch   = (r_state == S_LATCH);

  // Bring sig_in into the clk domain and keep the previous sample for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; dropping en inside a gate abandons it
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (en) w_state_next = S_GATE;
        else    w_state_next = S_IDLE;
      end
      S_GATE: begin
        if (!en)                          w_state_next = S_IDLE;
        else if (r_gate_cnt == GC_LAST)   w_state_next = S_LATCH;
        else                              w_state_next = S_GATE;
      end
      S_LATCH: begin
        if (en) w_state_next = S_GATE;
        else    w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Busy flag follows the state being entered so it is itself a register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_state_next != S_IDLE);
    end
  end

  // Gate timing and saturating edge accumulation; cleared outside an active gate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gate_cnt <= {GW{1'b0}};
      r_edge_cnt <= {count_width{1'b0}};
      r_ovf      <= 1'b0;
    end else if (w_in_gate) begin
      r_gate_cnt <= r_gate_cnt + GW'(1);
      if (w_edge) begin
        if (r_edge_cnt == CNT_MAX) r_ovf <= 1'b1;
        else                       r_edge_cnt <= r_edge_cnt + count_width'(1);
      end else begin
        r_edge_cnt <= r_edge_cnt;
      end
    end else begin
      r_gate_cnt <= {GW{1'b0}};
      r_edge_cnt <= {count_width{1'b0}};
      r_ovf      <= 1'b0;
    end
  end

`ifdef FREQ_METER_BCD_EN
  localparam int BW = $clog2(count_width + 1);

  logic [count_width-1:0]  r_sh_cnt;
  logic [count_width-1:0]  r_shift;
  logic                    r_sh_ovf;
  logic                    r_conv;
  logic [BW-1:0]           r_bits;
  logic [4*bcd_digits-1:0] r_acc;
  logic [4*bcd_digits-1:0] r_bcd;
  logic [4*bcd_digits-1:0] w_acc_adj;

  // Double-dabble correction: add 3 to every digit that is 5 or more
  function automatic logic [4*bcd_digits-1:0] dd_adjust(input logic [4*bcd_digits-1:0] a);
    logic [4*bcd_digits-1:0] r;
    r = a;
    for (int d = 0; d < bcd_digits; d++) begin
      if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
      else                     r[4*d +: 4] = r[4*d +: 4];
    end
    return r;
  endfunction

  assign w_acc_adj = dd_adjust(r_acc);

  // Convert the latched count one bit per clk during the next gate, then publish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_cnt     <= {count_width{1'b0}};
      r_shift      <= {count_width{1'b0}};
      r_sh_ovf     <= 1'b0;
      r_conv       <= 1'b0;
      r_bits       <= {BW{1'b0}};
      r_acc        <= {(4*bcd_digits){1'b0}};
      r_bcd        <= {(4*bcd_digits){1'b0}};
      r_freq       <= {count_width{1'b0}};
      r_overflow   <= 1'b0;
      r_freq_valid <= 1'b0;
    end else begin
      r_freq_valid <= 1'b0;
      if (w_latch) begin
        r_sh_cnt <= r_edge_cnt;
        r_shift  <= r_edge_cnt;
        r_sh_ovf <= r_ovf;
        r_acc    <= {(4*bcd_digits){1'b0}};
        r_bits   <= BW'(count_width);
        r_conv   <= 1'b1;
      end else if (w_abort) begin
        r_conv <= 1'b0;
      end else if (r_conv) begin
        if (r_bits != {BW{1'b0}}) begin
          r_acc   <= {w_acc_adj[4*bcd_digits-2:0], r_shift[count_width-1]};
          r_shift <= {r_shift[count_width-2:0], 1'b0};
          r_bits  <= r_bits - BW'(1);
        end else begin
          r_conv       <= 1'b0;
          r_bcd        <= r_acc;
          r_freq       <= r_sh_cnt;
          r_overflow   <= r_sh_ovf;
          r_freq_valid <= 1'b1;
        end
      end else begin
        r_conv <= 1'b0;
      end
    end
  end

  assign bcd = r_bcd;
`else
  // Publish the completed count straight from the LATCH state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_freq       <= {count_width{1'b0}};
      r_overflow   <= 1'b0;
      r_freq_valid <= 1'b0;
    end else begin
      r_freq_valid <= w_latch;
      if (w_latch) begin
        r_freq     <= r_edge_cnt;
        r_overflow <= r_ovf;
      end else begin
        r_freq     <= r_freq;
        r_overflow <= r_overflow;
      end
    end
  end
`endif

  assign freq       = r_freq;
  assign freq_valid = r_freq_valid;
  assign overflow   = r_overflow;
  assign busy       = r_busy;

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: randomized self-checking bench for freq_meter.
// Two instances (32-bit and 8-bit counters) share stimulus; expected results
// are computed from a log of the sig_in value seen at every clk edge.
`timescale 1ns/1ps
module tb_freq_meter;
  localparam int GC = 1000;
`ifdef FREQ_METER_BCD_EN
  localparam int LAT32 = 33;
  localparam int LAT8  = 9;
`else
  localparam int LAT32 = 0;
  localparam int LAT8  = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  logic sig_in = 1'b0;
  logic [31:0] freq32;
  logic v32, o32, b32;
  logic [7:0] freq8;
  logic v8, o8, b8;
`ifdef FREQ_METER_BCD_EN
  logic [39:0] bcd32;
  logic [11:0] bcd8;
`else
  wire  [39:0] bcd32 = 40'd0;
  wire  [11:0] bcd8  = 12'd0;
`endif

  freq_meter #(.clock_frequency(1), .gate_ms(1), .count_width(32), .bcd_digits(10)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
    .freq(freq32), .freq_valid(v32), .overflow(o32), .busy(b32)
`ifdef FREQ_METER_BCD_EN
    , .bcd(bcd32)
`endif
  );

  freq_meter #(.clock_frequency(1), .gate_ms(1), .count_width(8), .bcd_digits(3)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
    .freq(freq8), .freq_valid(v8), .overflow(o8), .busy(b8)
`ifdef FREQ_METER_BCD_EN
    , .bcd(bcd8)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit hist [0:65535];

  // stimulus shape: 0 constant level, 1 periodic, 2 random phase lengths
  int mode = 0;
  int per = 10;
  bit lvl = 1'b0;
  int ph = 0;
  int hold = 1;

  int n_str32 = 0, n_str8 = 0, exp_str32 = 0, exp_str8 = 0;
  int str_cyc32 = 0, str_cyc8 = 0;
  logic [31:0] str_f32;
  logic [7:0]  str_f8;
  logic str_o32, str_o8;
  logic [39:0] str_b32;
  logic [11:0] str_b8;
  int last_r32 = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // cycle counter and log of what the DUT input flops capture at each edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    hist[cyc] = rst_n && sig_in;
  end

  // record every strobe with the values present alongside it
  always @(negedge clk) begin
    if (v32 === 1'b1) begin
      n_str32++; str_cyc32 = cyc; str_f32 = freq32; str_o32 = o32; str_b32 = bcd32;
    end
    if (v8 === 1'b1) begin
      n_str8++; str_cyc8 = cyc; str_f8 = freq8; str_o8 = o8; str_b8 = bcd8;
    end
  end

  // sig_in generator, changing just after each rising clk edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: sig_in = lvl;
        1: begin
          ph = (ph + 1 >= per) ? 0 : ph + 1;
          sig_in = (ph < per / 2);
        end
        default: begin
          if (hold <= 1) begin
            sig_in = ~sig_in;
            hold = $urandom_range(1, 8);
          end else begin
            hold--;
          end
        end
      endcase
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  function automatic int count_rises(input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++) begin
      if (k >= 1 && hist[k] && !hist[k-1]) n++;
    end
    return n;
  endfunction

  function automatic logic [63:0] to_bcd(input longint v, input int nd);
    logic [63:0] b = 64'd0;
    longint x = v;
    for (int i = 0; i < nd; i++) begin
      b[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return b;
  endfunction

  task automatic wait_pos(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_neg(input int t);
    wait_pos(t);
    @(negedge clk);
    #1;
  endtask

  // one gate starting at edge g: strobe cycle, strobe count and values
  task automatic check_gate(input int g, input string tag);
    int r;
    int e8;
    wait_neg(g + GC + 1 + LAT32);
    r  = count_rises(g - 1, g + GC - 2);
    e8 = (r > 255) ? 255 : r;
    exp_str32++;
    exp_str8++;
    check_eq({tag, "_nstrobe32"}, n_str32, exp_str32);
    check_eq({tag, "_nstrobe8"}, n_str8, exp_str8);
    exp_str32 = n_str32;
    exp_str8  = n_str8;
    check_eq({tag, "_cyc32"}, str_cyc32, g + GC + 1 + LAT32);
    check_eq({tag, "_cyc8"}, str_cyc8, g + GC + 1 + LAT8);
    check_eq({tag, "_freq32"}, str_f32, r);
    check_eq({tag, "_ovf32"}, str_o32, 0);
    check_eq({tag, "_freq8"}, str_f8, e8);
    check_eq({tag, "_ovf8"}, str_o8, (r > 255) ? 1 : 0);
`ifdef FREQ_METER_BCD_EN
    check_eq({tag, "_bcd32"}, str_b32, to_bcd(r, 10));
    check_eq({tag, "_bcd8"}, str_b8, to_bcd(e8, 3));
`endif
    last_r32 = r;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_freq32"}, freq32, 0);
    check_eq({tag, "_freq8"}, freq8, 0);
    check_eq({tag, "_valid"}, {v32, v8}, 0);
    check_eq({tag, "_ovf"}, {o32, o8}, 0);
    check_eq({tag, "_busy"}, {b32, b8}, 0);
    check_eq({tag, "_bcd"}, {bcd32, bcd8}, 0);
  endtask

  initial begin
    int a;
    int g;
    #2 rst_n = 1'b0;
    #1 check_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mode = 1; per = 10;
    wait_pos(cyc + 5);

    // scenario 1: continuous 10-clk square wave
    a = cyc; en = 1'b1; g = a + 1;
    wait_neg(g);
    check_eq("s1_busy", {b32, b8}, 2'b11);
    check_gate(g, "s1_g0");
    check_eq("s1_lit0", str_f32, 100);
    check_eq("s1_lat", str_cyc32 - a, GC + 2 + LAT32);
    g += GC + 1;
    check_gate(g, "s1_g1");
    check_eq("s1_lit1", str_f32, 100);

    // scenario 3: overflow of the 8-bit counter, then recovery
    mode = 1; per = 2;
    g += GC + 1; check_gate(g, "s3_mix");
    g += GC + 1; check_gate(g, "s3_ovf");
    check_eq("s3_lit_f8", str_f8, 255);
    check_eq("s3_lit_o8", str_o8, 1);
    check_eq("s3_lit_f32", str_f32, 500);
    per = 10;
    g += GC + 1; check_gate(g, "s3_mix2");
    g += GC + 1; check_gate(g, "s3_rec");
    check_eq("s3_rec_f8", str_f8, 100);
    check_eq("s3_rec_o8", str_o8, 0);

    // scenario 2: static input low then high
    mode = 0; lvl = 1'b0;
    g += GC + 1; check_gate(g, "s2_lo0");
    g += GC + 1; check_gate(g, "s2_lo1");
    check_eq("s2_lo_lit", str_f32, 0);
    lvl = 1'b1;
    g += GC + 1; check_gate(g, "s2_hi0");
    g += GC + 1; check_gate(g, "s2_hi1");
    check_eq("s2_hi_lit", str_f32, 0);

    // random phase lengths
    mode = 2;
    for (int i = 0; i < 4; i++) begin
      g += GC + 1; check_gate(g, "rnd");
    end

    // scenario 4: abort at gate cycle 400
    mode = 1; per = 10;
    g += GC + 1; check_gate(g, "s4_pre0");
    g += GC + 1; check_gate(g, "s4_pre1");
    check_eq("s4_pre_lit", str_f32, 100);
    g += GC + 1;
    wait_pos(g + 400);
    en = 1'b0;
    wait_neg(g + 401);
    check_eq("s4_busy", {b32, b8}, 0);
    check_eq("s4_valid", {v32, v8}, 0);
    check_eq("s4_hold", freq32, last_r32);
    wait_neg(g + GC + LAT32 + 10);
    check_eq("s4_nostrobe", n_str32 + n_str8, exp_str32 + exp_str8);
    check_eq("s4_hold2", freq32, 100);
    @(posedge clk); #1;
    a = cyc; en = 1'b1; g = a + 1;
    check_gate(g, "s4_fresh");

    // scenario 5: reset pulse at gate cycle 500
    g += GC + 1;
    wait_pos(g + 500);
    rst_n = 1'b0;
    #1 check_zero("s5_async");
    mode = 1; per = 8;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    a = cyc; g = a + 1;
    check_gate(g, "s5_after");
    check_eq("s5_lat", str_cyc32 - a, GC + 2 + LAT32);

    // scenario 6: 8-clk period, 125 edges
    g += GC + 1; check_gate(g, "s6");
    check_eq("s6_lit", str_f32, 125);
`ifdef FREQ_METER_BCD_EN
    check_eq("s6_bcd_lit", str_b32, 40'h0000000125);
`endif

    // idle holds the last result
    wait_pos(cyc + 100);
    en = 1'b0;
    wait_neg(cyc + 60);
    check_eq("idle_busy", {b32, b8}, 0);
    check_eq("idle_hold", freq32, 125);
    check_eq("idle_nostrobe", n_str32, exp_str32);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
